// File: rtl/edge_setup.sv
// Edge-function setup for the quad rasterizer: computes the six edge values at
// (0,0) once per frame with a shared multiplier, then steps them one line at a time.
module edge_setup #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned W_IN      = 11,
  parameter int unsigned W_ACC     = 24,
  parameter int unsigned W_OUT     = 20
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [9:0]              x,
  input  logic [9:0]              y,
  input  logic signed [W_IN-1:0]  x_screen_v0,
  input  logic signed [W_IN-1:0]  x_screen_v1,
  input  logic signed [W_IN-1:0]  x_screen_v2,
  input  logic signed [W_IN-1:0]  x_screen_v3,
  input  logic signed [W_IN-1:0]  y_screen_v0,
  input  logic signed [W_IN-1:0]  y_screen_v1,
  input  logic signed [W_IN-1:0]  y_screen_v2,
  input  logic signed [W_IN-1:0]  y_screen_v3,
  output logic signed [W_OUT-1:0] e0_init_t1,
  output logic signed [W_OUT-1:0] e1_init_t1,
  output logic signed [W_OUT-1:0] e2_init_t1,
  output logic signed [W_OUT-1:0] e0_init_t2,
  output logic signed [W_OUT-1:0] e1_init_t2,
  output logic signed [W_OUT-1:0] e2_init_t2,
  output logic                    setup_busy,
  output logic                    frame_done
);

  localparam int unsigned N_EDGE = 6;
  localparam int unsigned W_PROD = 2 * W_IN;
  localparam logic [9:0]  X_STEP = 10'(H_VISIBLE);
  localparam logic [9:0]  Y_TRIG = 10'(V_VISIBLE);
  localparam logic [3:0]  K_LAST = 4'd11;
  localparam logic signed [W_ACC-1:0] SAT_HI = W_ACC'((1 << (W_OUT - 1)) - 1);
  localparam logic signed [W_ACC-1:0] SAT_LO = -SAT_HI;

  typedef enum logic [1:0] {IDLE, LATCH, MUL, DONE} state_t;

  state_t state, state_nx;
  logic [3:0] k;
  logic [2:0] edge_idx;
  logic [1:0] mi, mj;
  logic trig, line_step;
  logic signed [W_IN-1:0]   in_x [4];
  logic signed [W_IN-1:0]   in_y [4];
  logic signed [W_IN-1:0]   lat_x [4];
  logic signed [W_IN-1:0]   lat_y [4];
  logic signed [W_IN-1:0]   op_a, op_b;
  logic signed [W_PROD-1:0] prod;
  logic signed [W_ACC-1:0]  prod_ext;
  logic signed [W_ACC-1:0]  acc;
  logic signed [W_ACC-1:0]  acc_edge [N_EDGE];
  logic signed [W_ACC-1:0]  step_s [N_EDGE];
  logic signed [W_ACC-1:0]  step_nx [N_EDGE];

  // Edge e runs from vertex edge_i(e) to vertex edge_j(e); 0..2 are t1, 3..5 are t2.
  function automatic logic [1:0] edge_i(input logic [2:0] e);
    case (e)
      3'd0:    return 2'd0;
      3'd1:    return 2'd1;
      3'd2:    return 2'd2;
      3'd3:    return 2'd0;
      3'd4:    return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic [1:0] edge_j(input logic [2:0] e);
    case (e)
      3'd0:    return 2'd1;
      3'd1:    return 2'd2;
      3'd2:    return 2'd0;
      3'd3:    return 2'd2;
      3'd4:    return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic signed [W_ACC-1:0] sext(input logic signed [W_IN-1:0] v);
    return {{(W_ACC - W_IN){v[W_IN-1]}}, v};
  endfunction

  function automatic logic signed [W_OUT-1:0] sat(input logic signed [W_ACC-1:0] v);
    if (v > SAT_HI) return W_OUT'(SAT_HI);
    if (v < SAT_LO) return W_OUT'(SAT_LO);
    return W_OUT'(v);
  endfunction

  assign in_x[0] = x_screen_v0;
  assign in_x[1] = x_screen_v1;
  assign in_x[2] = x_screen_v2;
  assign in_x[3] = x_screen_v3;
  assign in_y[0] = y_screen_v0;
  assign in_y[1] = y_screen_v1;
  assign in_y[2] = y_screen_v2;
  assign in_y[3] = y_screen_v3;

  assign trig      = (y == Y_TRIG) && (x == 10'd0);
  assign line_step = (y < Y_TRIG) && (x == X_STEP);

  // Shared multiplier: even k forms yi*xj, odd k forms xi*yj for edge k>>1.
  assign edge_idx = k[3:1];
  assign mi       = edge_i(edge_idx);
  assign mj       = edge_j(edge_idx);
  assign op_a     = k[0] ? lat_x[mi] : lat_y[mi];
  assign op_b     = k[0] ? lat_y[mj] : lat_x[mj];
  assign prod     = W_PROD'(op_a) * W_PROD'(op_b);
  assign prod_ext = {{(W_ACC - W_PROD){prod[W_PROD-1]}}, prod};

  always_comb begin
    for (int unsigned e = 0; e < N_EDGE; e++) begin
      step_nx[e] = sext(in_x[edge_i(3'(e))]) - sext(in_x[edge_j(3'(e))]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (trig) state_nx = LATCH;
      LATCH:   state_nx = MUL;
      MUL:     if (k == K_LAST) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      setup_busy <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      setup_busy <= (state_nx == LATCH) || (state_nx == MUL);
      frame_done <= (state_nx == DONE);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k   <= 4'd0;
      acc <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        lat_x[i] <= '0;
        lat_y[i] <= '0;
      end
      for (int unsigned e = 0; e < N_EDGE; e++) begin
        acc_edge[e] <= '0;
        step_s[e]   <= '0;
      end
    end else begin
      if (state == LATCH) begin
        k <= 4'd0;
        for (int unsigned i = 0; i < 4; i++) begin
          lat_x[i] <= in_x[i];
          lat_y[i] <= in_y[i];
        end
        for (int unsigned e = 0; e < N_EDGE; e++) step_s[e] <= step_nx[e];
      end
      if (state == MUL) begin
        k <= k + 4'd1;
        if (!k[0]) acc <= prod_ext;
      end
      // Frame writes and line steps live on disjoint lines, so they never collide.
      for (int unsigned e = 0; e < N_EDGE; e++) begin
        if ((state == MUL) && k[0] && (edge_idx == 3'(e))) acc_edge[e] <= acc - prod_ext;
        else if (line_step)                                 acc_edge[e] <= acc_edge[e] + step_s[e];
      end
    end
  end

  assign e0_init_t1 = sat(acc_edge[0]);
  assign e1_init_t1 = sat(acc_edge[1]);
  assign e2_init_t1 = sat(acc_edge[2]);
  assign e0_init_t2 = sat(acc_edge[3]);
  assign e1_init_t2 = sat(acc_edge[4]);
  assign e2_init_t2 = sat(acc_edge[5]);

endmodule

// File: tb/tb_edge_setup.sv
// Bench for edge_setup: closed-form edge model (C + n*S per edge) checked every
// cycle, plus literal expectations from hand-worked quads.
module tb_edge_setup;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [9:0] x = '0;
  logic [9:0] y = '0;
  logic signed [10:0] vx [4];
  logic signed [10:0] vy [4];
  logic signed [19:0] e_out [6];
  logic setup_busy, frame_done;

  int tests = 0;
  int fails = 0;
  bit jitter = 1'b0;

  always #5 clk = ~clk;

  edge_setup dut (
    .clk(clk), .reset_n(reset_n), .x(x), .y(y),
    .x_screen_v0(vx[0]), .x_screen_v1(vx[1]), .x_screen_v2(vx[2]), .x_screen_v3(vx[3]),
    .y_screen_v0(vy[0]), .y_screen_v1(vy[1]), .y_screen_v2(vy[2]), .y_screen_v3(vy[3]),
    .e0_init_t1(e_out[0]), .e1_init_t1(e_out[1]), .e2_init_t1(e_out[2]),
    .e0_init_t2(e_out[3]), .e1_init_t2(e_out[4]), .e2_init_t2(e_out[5]),
    .setup_busy(setup_busy), .frame_done(frame_done)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t x=%0d y=%0d)", name, act, exp, $time, x, y);
    end
  endtask

  // Reference model: edge e spans vertices (ei[e], ej[e]); its value is C + n*S.
  int     ei [6] = '{0, 1, 2, 0, 2, 3};
  int     ej [6] = '{1, 2, 0, 2, 3, 0};
  int     phase = 0;
  longint nstep = 0;
  longint mc [6], ms [6], pc [6], ps [6];

  function automatic longint wrap24(input longint v);
    logic signed [23:0] t;
    t = v[23:0];
    return longint'(t);
  endfunction

  function automatic longint sat20(input longint v);
    if (v > 524287)  return 524287;
    if (v < -524287) return -524287;
    return v;
  endfunction

  task automatic model_reset();
    phase = 0;
    nstep = 0;
    for (int e = 0; e < 6; e++) begin
      mc[e] = 0; ms[e] = 0; pc[e] = 0; ps[e] = 0;
    end
  endtask

  initial model_reset();

  always @(negedge clk) begin
    if (!reset_n) model_reset();
    if (phase < 2 || phase > 13) begin
      for (int e = 0; e < 6; e++)
        chk($sformatf("model e_init[%0d]", e), e_out[e], sat20(wrap24(mc[e] + nstep * ms[e])));
    end
    chk("model setup_busy", setup_busy, (phase >= 1 && phase <= 13));
    chk("model frame_done", frame_done, (phase == 14));
    if (reset_n) begin
      if (phase == 0) begin
        if (y == 10'd480 && x == 10'd0) phase = 1;
      end else begin
        if (phase == 1) begin
          for (int e = 0; e < 6; e++) begin
            pc[e] = longint'(vy[ei[e]]) * longint'(vx[ej[e]]) - longint'(vx[ei[e]]) * longint'(vy[ej[e]]);
            ps[e] = longint'(vx[ei[e]]) - longint'(vx[ej[e]]);
          end
        end
        if (phase == 13) begin
          for (int e = 0; e < 6; e++) begin
            mc[e] = pc[e];
            ms[e] = ps[e];
          end
          nstep = 0;
        end
        phase = (phase == 14) ? 0 : phase + 1;
      end
      if (y < 10'd480 && x == 10'd640) nstep++;
    end
  end

  task automatic rand_vtx();
    for (int i = 0; i < 4; i++) begin
      vx[i] = 11'($urandom_range(0, 2047));
      vy[i] = 11'($urandom_range(0, 2047));
    end
  endtask

  task automatic set_vtx(input int x0, y0, x1, y1, x2, y2, x3, y3);
    vx[0] = 11'(x0); vy[0] = 11'(y0);
    vx[1] = 11'(x1); vy[1] = 11'(y1);
    vx[2] = 11'(x2); vy[2] = 11'(y2);
    vx[3] = 11'(x3); vy[3] = 11'(y3);
  endtask

  task automatic cycle(input int xv, input int yv);
    @(posedge clk);
    #1;
    x = 10'(xv);
    y = 10'(yv);
    if (jitter) rand_vtx();
  endtask

  task automatic line(input int yv);
    cycle(0, yv);
    cycle(1, yv);
    cycle(int'($urandom_range(2, 638)), yv);
    cycle(640, yv);
    cycle(641, yv);
    cycle(799, yv);
  endtask

  task automatic blank_lines();
    for (int yy = 481; yy < 525; yy++) begin
      cycle(0, yy);
      cycle(640, yy);
      cycle(799, yy);
    end
  endtask

  // Setup line; dup re-issues the trigger while the computation is running.
  task automatic setup_line(input bit dup);
    for (int xv = 0; xv < 20; xv++) begin
      cycle((dup && xv == 6) ? 0 : xv, 480);
      chk("frame_done timing", frame_done, (xv == 14));
    end
    cycle(640, 480);
    cycle(799, 480);
  endtask

  task automatic chk_six(input string name, input longint exp [6]);
    for (int e = 0; e < 6; e++) chk($sformatf("%s[%0d]", name, e), e_out[e], exp[e]);
  endtask

  longint c_quad [6]  = '{20000, -80000, 20000, -20000, 60000, 0};
  longint c_line0 [6] = '{19800, -79800, 20000, -20000, 59800, 200};
  longint zeros [6]   = '{0, 0, 0, 0, 0, 0};

  initial begin
    set_vtx(0, 0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_six("reset e_init", zeros);
    chk("reset setup_busy", setup_busy, 0);
    chk("reset frame_done", frame_done, 0);
    reset_n = 1'b1;

    // Axis-aligned quad, full frame with a vertex change at line 100.
    set_vtx(100, 100, 300, 100, 100, 300, 300, 300);
    setup_line(1'b0);
    blank_lines();
    chk_six("quad C at (524,799)", c_quad);
    for (int yy = 0; yy < 480; yy++) begin
      if (yy == 100) rand_vtx();
      line(yy);
      if (yy == 0) chk_six("quad at (0,799)", c_line0);
      if (yy == 9) begin
        chk("quad t1 e0 at (9,799)", e_out[0], 18000);
        chk("quad t2 e2 at (9,799)", e_out[5], 2000);
      end
      if (yy == 100) chk("old-vertex step t1 e0 at (100,799)", e_out[0], -200);
      if (yy == 479) begin
        chk("t1 e0 at (479,799)", e_out[0], -76000);
        chk("t2 e1 at (479,799)", e_out[4], -36000);
      end
    end

    // Saturation: internal value 2094081 clamps to 524287 and stays there after a step.
    set_vtx(-1024, 1023, 1023, 1023, 0, 0, 0, 0);
    setup_line(1'b0);
    blank_lines();
    chk("sat t1 e0 at (524,799)", e_out[0], 524287);
    line(0);
    chk("sat t1 e0 at (0,799)", e_out[0], 524287);
    chk("sat t1 e1 at (0,799)", e_out[1], 1023);
    chk("sat t2 e0 at (0,799)", e_out[3], -1024);

    // Reset asserted during the seventh MUL cycle.
    set_vtx(100, 100, 300, 100, 100, 300, 300, 300);
    for (int xv = 0; xv < 9; xv++) cycle(xv, 480);
    #1;
    reset_n = 1'b0;
    #1;
    chk_six("mid-MUL reset e_init", zeros);
    chk("mid-MUL reset setup_busy", setup_busy, 0);
    for (int xv = 9; xv < 12; xv++) cycle(xv, 480);
    reset_n = 1'b1;
    for (int xv = 12; xv < 20; xv++) begin
      cycle(xv, 480);
      chk("no frame_done after reset", frame_done, 0);
    end
    for (int yy = 0; yy < 3; yy++) line(yy);
    chk_six("post-reset e_init at (2,799)", zeros);
    setup_line(1'b0);
    blank_lines();
    chk_six("post-reset quad C at (524,799)", c_quad);

    // Random vertices that wander every cycle, with a duplicate trigger during setup.
    jitter = 1'b1;
    for (int f = 0; f < 5; f++) begin
      setup_line(1'b1);
      blank_lines();
      for (int yy = 0; yy < 480; yy++) line(yy);
    end
    jitter = 1'b0;
    repeat (4) cycle(0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
